bp_update_scheduler: RTL and testbench

BP_UPDATE_SCHEDULER -- requirements
Module: bp_update_scheduler

---
 rtl/bp_update_scheduler_pkg.sv | 18 +
 rtl/bp_update_fifo.sv | 78 +++++++
 rtl/bp_update_scheduler.sv | 147 ++++++++++++++
 tb/tb_bp_update_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_update_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// bp_update_scheduler_pkg
// Shared types for the branch-predictor update scheduler.
//   NO_ENTRY_ID : all-ones predictor entry ID meaning "no entry" (slice to
//                 the ID width in use).
//   bp_entry_t  : one pending predictor update (branch PC, target, jump flag).
// ---------------------------------------------------------------------------
package bp_update_scheduler_pkg;

    localparam logic [31:0] NO_ENTRY_ID = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] dest;
        logic        is_jump;
    } bp_entry_t;

endpackage

// File: rtl/bp_update_fifo.sv
// ---------------------------------------------------------------------------
// bp_update_fifo
// Pending-update storage: up to two writes and one read per cycle.
//   clk, rst      : clock, asynchronous active-low reset
//   clr           : synchronous clear of pointers and count
//   wr_cnt        : number of entries written this cycle (0..2)
//   wr_d0, wr_d1  : entries to write; wr_d0 goes in first
//   rd_en         : pop the head (only when count != 0)
//   rd_data       : current head entry
//   count         : occupancy, log2(DEPTH)+1 bits
//   slot_valid    : per-slot occupied flag (physical slot order)
//   slot_addr     : per-slot branch address, flattened 32 bits per slot
// ---------------------------------------------------------------------------
module bp_update_fifo
    import bp_update_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [1:0]            wr_cnt,
    input  bp_entry_t             wr_d0,
    input  bp_entry_t             wr_d1,
    input  logic                  rd_en,
    output bp_entry_t             rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [DEPTH-1:0]      slot_valid,
    output logic [DEPTH*32-1:0]   slot_addr
);
    localparam int AW = $clog2(DEPTH);

    bp_entry_t      mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  wr_ptr_p1;
    logic [AW-1:0]  slot_off;

    assign wr_ptr_p1 = wr_ptr + AW'(1);
    assign rd_data   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_cnt);
            rd_ptr <= rd_ptr + AW'(rd_en);
            count  <= count + (AW+1)'(wr_cnt) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_cnt != 2'd0) mem[wr_ptr]    <= wr_d0;
        if (wr_cnt == 2'd2) mem[wr_ptr_p1] <= wr_d1;
    end

    // A slot is occupied when its distance from the read pointer is below count.
    always_comb begin
        slot_valid = '0;
        slot_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off      = AW'(i) - rd_ptr;
            slot_valid[i] = ({1'b0, slot_off} < count);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign slot_addr[g*32 +: 32] = mem[g].addr;
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// ---------------------------------------------------------------------------
// bp_update_scheduler
// Collects taken-branch reports from two branch units, removes duplicates,
// queues them and issues one predictor update per cycle.
//   clk, rst              : clock, asynchronous active-low reset
//   IN_valid[1:0]         : per-port report valid, port 0 is older
//   IN_branchID           : per-port predictor ID, port 0 in the low bits
//   IN_branchAddr/Dest    : per-port branch PC / target, port 0 in [31:0]
//   IN_branchTaken/IsJump : per-port outcome and jump flag
//   IN_flush              : discard all pending updates and this cycle's reports
//   OUT_stall             : branch units must not report next cycle
//   OUT_branch*           : registered single update port to the predictor
//   OUT_dropCount         : saturating count of discarded duplicates
// Valid/ready note: there is no ready on either side. Upstream obeys the
// registered OUT_stall; downstream accepts every OUT_branchValid cycle.
// ---------------------------------------------------------------------------
module bp_update_scheduler
    import bp_update_scheduler_pkg::*;
#(
    parameter int ID_BITS = 6,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           IN_valid,
    input  logic [2*ID_BITS-1:0] IN_branchID,
    input  logic [63:0]          IN_branchAddr,
    input  logic [63:0]          IN_branchDest,
    input  logic [1:0]           IN_branchTaken,
    input  logic [1:0]           IN_branchIsJump,
    input  logic                 IN_flush,
    output logic                 OUT_stall,
    output logic                 OUT_branchValid,
    output logic [ID_BITS-1:0]   OUT_branchID,
    output logic [31:0]          OUT_branchAddr,
    output logic [31:0]          OUT_branchDest,
    output logic                 OUT_branchTaken,
    output logic                 OUT_branchIsJump,
    output logic [7:0]           OUT_dropCount
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [ID_BITS-1:0] NO_ID = NO_ENTRY_ID[ID_BITS-1:0];

    bp_entry_t        ent0, ent1, q_head, wr_d0, wr_d1, load_ent;
    logic [AW:0]      q_count, count_next;
    logic [DEPTH-1:0] q_slot_valid;
    logic [DEPTH*32-1:0] q_slot_addr;
    logic [1:0]       elig, match, dup, acc, wr_cnt;
    logic             blocked, bypass, deq, load_en;
    logic [8:0]       drop_sum;

    assign ent0 = '{addr: IN_branchAddr[31:0],  dest: IN_branchDest[31:0],  is_jump: IN_branchIsJump[0]};
    assign ent1 = '{addr: IN_branchAddr[63:32], dest: IN_branchDest[63:32], is_jump: IN_branchIsJump[1]};
    assign OUT_branchID = NO_ID;

    always_comb begin
        elig[0] = IN_valid[0] & IN_branchTaken[0] & (IN_branchID[ID_BITS-1:0] == NO_ID);
        elig[1] = IN_valid[1] & IN_branchTaken[1] & (IN_branchID[2*ID_BITS-1:ID_BITS] == NO_ID);

        // Duplicate = same PC already waiting in the queue; port 1 also
        // collides with an eligible port-0 report of the same cycle.
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_slot_valid[i] && q_slot_addr[i*32 +: 32] == ent0.addr) match[0] = 1'b1;
            if (q_slot_valid[i] && q_slot_addr[i*32 +: 32] == ent1.addr) match[1] = 1'b1;
        end
        if (elig[0] && ent1.addr == ent0.addr) match[1] = 1'b1;

        // Full queue is an upstream protocol error: drop silently, no counting.
        blocked = IN_flush | (q_count == (AW+1)'(DEPTH));
        dup     = blocked ? 2'b00 : (elig & match);
        acc     = blocked ? 2'b00 : (elig & ~match);
        if (&acc && q_count == (AW+1)'(DEPTH-1)) acc[1] = 1'b0;

        deq    = (q_count != '0);
        bypass = (q_count == '0) && (|acc);

        // With an empty queue the oldest accepted report skips storage and
        // goes straight to the output register; only the other one is queued.
        wr_cnt = 2'd0;
        wr_d0  = ent0;
        wr_d1  = ent1;
        if (bypass) begin
            if (&acc) begin
                wr_cnt = 2'd1;
                wr_d0  = ent1;
            end
        end else begin
            case (acc)
                2'b01:   wr_cnt = 2'd1;
                2'b10: begin
                    wr_cnt = 2'd1;
                    wr_d0  = ent1;
                end
                2'b11:   wr_cnt = 2'd2;
                default: wr_cnt = 2'd0;
            endcase
        end

        count_next = IN_flush ? '0 : (q_count + (AW+1)'(wr_cnt) - (AW+1)'(deq));
        drop_sum   = {1'b0, OUT_dropCount} + 9'(dup[0]) + 9'(dup[1]);

        load_en  = deq | bypass;
        load_ent = deq ? q_head : (acc[0] ? ent0 : ent1);
    end

    bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (IN_flush),
        .wr_cnt     (wr_cnt),
        .wr_d0      (wr_d0),
        .wr_d1      (wr_d1),
        .rd_en      (deq),
        .rd_data    (q_head),
        .count      (q_count),
        .slot_valid (q_slot_valid),
        .slot_addr  (q_slot_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OUT_stall        <= 1'b0;
            OUT_dropCount    <= 8'd0;
            OUT_branchValid  <= 1'b0;
            OUT_branchAddr   <= '0;
            OUT_branchDest   <= '0;
            OUT_branchTaken  <= 1'b0;
            OUT_branchIsJump <= 1'b0;
        end else begin
            OUT_stall     <= (count_next > (AW+1)'(DEPTH-2));
            OUT_dropCount <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (IN_flush) begin
                OUT_branchValid <= 1'b0;
            end else if (load_en) begin
                OUT_branchValid  <= 1'b1;
                OUT_branchAddr   <= load_ent.addr;
                OUT_branchDest   <= load_ent.dest;
                OUT_branchTaken  <= 1'b1;
                OUT_branchIsJump <= load_ent.is_jump;
            end else begin
                OUT_branchValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bp_update_scheduler
// Table of per-cycle report vectors with hand-computed outputs, followed by
// hand-written sequences for saturation, flush and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_bp_update_scheduler;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [5:0]  id;
        logic [31:0] addr;
        logic [31:0] dest;
        logic        jump;
    } rpt_t;

    typedef struct packed {
        rpt_t        p0;
        rpt_t        p1;
        logic        flush;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_dest;
        logic        e_jump;
        logic        e_stall;
        logic [7:0]  e_drop;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [1:0]  IN_valid;
    logic [11:0] IN_branchID;
    logic [63:0] IN_branchAddr;
    logic [63:0] IN_branchDest;
    logic [1:0]  IN_branchTaken;
    logic [1:0]  IN_branchIsJump;
    logic        IN_flush;
    logic        OUT_stall;
    logic        OUT_branchValid;
    logic [5:0]  OUT_branchID;
    logic [31:0] OUT_branchAddr;
    logic [31:0] OUT_branchDest;
    logic        OUT_branchTaken;
    logic        OUT_branchIsJump;
    logic [7:0]  OUT_dropCount;

    int vec_count  = 0;
    int miscompares = 0;
    vec_t tbl [16];
    rpt_t none_r;
    rpt_t tmp0, tmp1;

    bp_update_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .IN_valid         (IN_valid),
        .IN_branchID      (IN_branchID),
        .IN_branchAddr    (IN_branchAddr),
        .IN_branchDest    (IN_branchDest),
        .IN_branchTaken   (IN_branchTaken),
        .IN_branchIsJump  (IN_branchIsJump),
        .IN_flush         (IN_flush),
        .OUT_stall        (OUT_stall),
        .OUT_branchValid  (OUT_branchValid),
        .OUT_branchID     (OUT_branchID),
        .OUT_branchAddr   (OUT_branchAddr),
        .OUT_branchDest   (OUT_branchDest),
        .OUT_branchTaken  (OUT_branchTaken),
        .OUT_branchIsJump (OUT_branchIsJump),
        .OUT_dropCount    (OUT_dropCount)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rpt_t rp(input logic [31:0] a, input logic [31:0] d, input logic j);
        rpt_t r;
        r.valid = 1'b1;
        r.taken = 1'b1;
        r.id    = 6'h3F;
        r.addr  = a;
        r.dest  = d;
        r.jump  = j;
        return r;
    endfunction

    function automatic vec_t mk(input rpt_t p0, input rpt_t p1, input logic fl,
                                input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                                input logic ej, input logic es, input logic [7:0] edr);
        vec_t v;
        v.p0 = p0;  v.p1 = p1;  v.flush = fl;
        v.e_valid = ev;  v.e_addr = ea;  v.e_dest = ed;
        v.e_jump = ej;  v.e_stall = es;  v.e_drop = edr;
        return v;
    endfunction

    // Driver tasks
    task automatic apply(input rpt_t p0, input rpt_t p1, input logic fl);
        if ((p0.valid || p1.valid) && OUT_stall === 1'b1) begin
            miscompares++;
            $display("FAIL protocol: report presented while OUT_stall=%b", OUT_stall);
        end
        IN_valid        = {p1.valid, p0.valid};
        IN_branchTaken  = {p1.taken, p0.taken};
        IN_branchID     = {p1.id, p0.id};
        IN_branchAddr   = {p1.addr, p0.addr};
        IN_branchDest   = {p1.dest, p0.dest};
        IN_branchIsJump = {p1.jump, p0.jump};
        IN_flush        = fl;
    endtask

    task automatic drive_cycle(input rpt_t p0, input rpt_t p1, input logic fl);
        apply(p0, p1, fl);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard compare
    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s: got %h, want %h", nm, fld, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input vec_t v);
        vec_count++;
        cmp(nm, "valid", 32'(OUT_branchValid),  32'(v.e_valid));
        cmp(nm, "addr",  OUT_branchAddr,        v.e_addr);
        cmp(nm, "dest",  OUT_branchDest,        v.e_dest);
        cmp(nm, "jump",  32'(OUT_branchIsJump), 32'(v.e_jump));
        cmp(nm, "stall", 32'(OUT_stall),        32'(v.e_stall));
        cmp(nm, "drop",  32'(OUT_dropCount),    32'(v.e_drop));
        cmp(nm, "id",    32'(OUT_branchID),     32'h3F);
        if (v.e_valid) cmp(nm, "taken", 32'(OUT_branchTaken), 32'd1);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        drive_cycle(v.p0, v.p1, v.flush);
        check_out(nm, v);
    endtask

    initial begin
        none_r = '0;
        // Table: each row is one cycle of reports and the outputs after that edge.
        tbl[0]  = mk(rp(32'h100, 32'h200, 1'b0), none_r, 1'b0, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 8'd0);
        tbl[1]  = mk(none_r, none_r, 1'b0, 1'b0, 32'h100, 32'h200, 1'b0, 1'b0, 8'd0);
        tbl[2]  = mk(rp(32'h40, 32'h44, 1'b0), rp(32'h40, 32'h48, 1'b1), 1'b0, 1'b1, 32'h40, 32'h44, 1'b0, 1'b0, 8'd1);
        tbl[3]  = mk(none_r, none_r, 1'b0, 1'b0, 32'h40, 32'h44, 1'b0, 1'b0, 8'd1);
        tmp0 = rp(32'h500, 32'h600, 1'b0);  tmp0.taken = 1'b0;
        tmp1 = rp(32'h504, 32'h604, 1'b0);  tmp1.id = 6'd5;
        tbl[4]  = mk(tmp0, tmp1, 1'b0, 1'b0, 32'h40, 32'h44, 1'b0, 1'b0, 8'd1);
        tbl[5]  = mk(rp(32'h1000, 32'h2000, 1'b1), rp(32'h1004, 32'h2004, 1'b0), 1'b0, 1'b1, 32'h1000, 32'h2000, 1'b1, 1'b0, 8'd1);
        tbl[6]  = mk(rp(32'h1100, 32'h2100, 1'b0), rp(32'h1104, 32'h2104, 1'b1), 1'b0, 1'b1, 32'h1004, 32'h2004, 1'b0, 1'b0, 8'd1);
        tbl[7]  = mk(rp(32'h1200, 32'h2200, 1'b0), rp(32'h1204, 32'h2204, 1'b0), 1'b0, 1'b1, 32'h1100, 32'h2100, 1'b0, 1'b1, 8'd1);
        tbl[8]  = mk(none_r, none_r, 1'b0, 1'b1, 32'h1104, 32'h2104, 1'b1, 1'b0, 8'd1);
        tbl[9]  = mk(none_r, none_r, 1'b0, 1'b1, 32'h1200, 32'h2200, 1'b0, 1'b0, 8'd1);
        tbl[10] = mk(none_r, none_r, 1'b0, 1'b1, 32'h1204, 32'h2204, 1'b0, 1'b0, 8'd1);
        tbl[11] = mk(none_r, none_r, 1'b0, 1'b0, 32'h1204, 32'h2204, 1'b0, 1'b0, 8'd1);
        tbl[12] = mk(rp(32'h3000, 32'h3100, 1'b0), rp(32'h3004, 32'h3104, 1'b0), 1'b0, 1'b1, 32'h3000, 32'h3100, 1'b0, 1'b0, 8'd1);
        tbl[13] = mk(rp(32'h3004, 32'h3999, 1'b0), rp(32'h3008, 32'h3108, 1'b1), 1'b0, 1'b1, 32'h3004, 32'h3104, 1'b0, 1'b0, 8'd2);
        tbl[14] = mk(none_r, none_r, 1'b0, 1'b1, 32'h3008, 32'h3108, 1'b1, 1'b0, 8'd2);
        tbl[15] = mk(none_r, none_r, 1'b0, 1'b0, 32'h3008, 32'h3108, 1'b1, 1'b0, 8'd2);

        // Reset state
        rst = 1'b1;
        IN_valid = '0; IN_branchTaken = '0; IN_branchID = '0;
        IN_branchAddr = '0; IN_branchDest = '0; IN_branchIsJump = '0; IN_flush = 1'b0;
        #1 rst = 1'b0;
        #10;
        check_out("reset", mk(none_r, none_r, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'd0));
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Drop counter saturation: one duplicate per cycle up to 254, then two at once.
        for (int i = 0; i < 252; i++) drive_cycle(rp(32'h40, 32'h44, 1'b0), rp(32'h40, 32'h48, 1'b1), 1'b0);
        check_out("sat_254", mk(none_r, none_r, 1'b0, 1'b1, 32'h40, 32'h44, 1'b0, 1'b0, 8'd254));
        run_vec("sat_a1", mk(rp(32'h5000, 32'h6000, 1'b0), rp(32'h5004, 32'h6004, 1'b1), 1'b0, 1'b1, 32'h5000, 32'h6000, 1'b0, 1'b0, 8'd254));
        run_vec("sat_b1", mk(rp(32'h5004, 32'h6004, 1'b1), rp(32'h5004, 32'h6004, 1'b1), 1'b0, 1'b1, 32'h5004, 32'h6004, 1'b1, 1'b0, 8'd255));
        run_vec("sat_a2", mk(rp(32'h5000, 32'h6000, 1'b0), rp(32'h5004, 32'h6004, 1'b1), 1'b0, 1'b1, 32'h5000, 32'h6000, 1'b0, 1'b0, 8'd255));
        run_vec("sat_b2", mk(rp(32'h5004, 32'h6004, 1'b1), rp(32'h5004, 32'h6004, 1'b1), 1'b0, 1'b1, 32'h5004, 32'h6004, 1'b1, 1'b0, 8'd255));
        run_vec("sat_idle", mk(none_r, none_r, 1'b0, 1'b0, 32'h5004, 32'h6004, 1'b1, 1'b0, 8'd255));

        // Flush with three entries queued: none of them may ever be issued.
        run_vec("fl_1", mk(rp(32'h7000, 32'h7100, 1'b0), rp(32'h7004, 32'h7104, 1'b0), 1'b0, 1'b1, 32'h7000, 32'h7100, 1'b0, 1'b0, 8'd255));
        run_vec("fl_2", mk(rp(32'h7008, 32'h7108, 1'b0), rp(32'h700C, 32'h710C, 1'b0), 1'b0, 1'b1, 32'h7004, 32'h7104, 1'b0, 1'b0, 8'd255));
        run_vec("fl_3", mk(rp(32'h7010, 32'h7110, 1'b0), rp(32'h7014, 32'h7114, 1'b0), 1'b0, 1'b1, 32'h7008, 32'h7108, 1'b0, 1'b1, 8'd255));
        run_vec("fl_4", mk(none_r, none_r, 1'b1, 1'b0, 32'h7008, 32'h7108, 1'b0, 1'b0, 8'd255));
        for (int i = 0; i < 3; i++)
            run_vec($sformatf("fl_idle%0d", i), mk(none_r, none_r, 1'b0, 1'b0, 32'h7008, 32'h7108, 1'b0, 1'b0, 8'd255));
        run_vec("fl_rpt", mk(rp(32'h7020, 32'h7120, 1'b0), rp(32'h7020, 32'h7124, 1'b0), 1'b1, 1'b0, 32'h7008, 32'h7108, 1'b0, 1'b0, 8'd255));
        run_vec("fl_after", mk(none_r, none_r, 1'b0, 1'b0, 32'h7008, 32'h7108, 1'b0, 1'b0, 8'd255));

        // Asynchronous reset in the middle of a drain.
        run_vec("rs_1", mk(rp(32'h8000, 32'h8100, 1'b1), rp(32'h8004, 32'h8104, 1'b0), 1'b0, 1'b1, 32'h8000, 32'h8100, 1'b1, 1'b0, 8'd255));
        run_vec("rs_2", mk(rp(32'h8008, 32'h8108, 1'b0), rp(32'h800C, 32'h810C, 1'b0), 1'b0, 1'b1, 32'h8004, 32'h8104, 1'b0, 1'b0, 8'd255));
        apply(none_r, none_r, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_out("rs_async", mk(none_r, none_r, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'd0));
        #2 rst = 1'b1;
        run_vec("rs_idle", mk(none_r, none_r, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'd0));
        run_vec("rs_rpt", mk(rp(32'h8800, 32'h8900, 1'b1), none_r, 1'b0, 1'b1, 32'h8800, 32'h8900, 1'b1, 1'b0, 8'd0));
        run_vec("rs_end", mk(none_r, none_r, 1'b0, 1'b0, 32'h8800, 32'h8900, 1'b1, 1'b0, 8'd0));

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
